keypad_scanner: RTL and testbench

//  Scans a physical 4x4 hex keypad (4 driven rows, 4 sensed columns), synchronises and

---
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad, synchronises and debounces the column
// sense lines, and publishes a key matrix indexed by hex key value together with
// one-cycle press/release events in ascending key order.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keypad_matrix,
  output logic        key_event,
  output logic [3:0]  key_event_index,
  output logic        key_event_press
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int RUN_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_SCANS);

  typedef enum logic {ST_IDLE, ST_WALK} state_t;

  // Physical position (row, column) to hex key value.
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hC;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hD;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'h0;  4'hE: k = 4'hB;  4'hF: k = 4'hF;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  logic [3:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic [15:0]      matrix_q, diff_q;
  state_t           state_q;
  logic [3:0]       ptr_q;
  logic             ev_q, ev_press_q;
  logic [3:0]       ev_idx_q;
  logic             sample_now, end_scan, accept;

  // Merge the current row's sample into the snapshot and evaluate debounce.
  always_comb begin
    raw_d = raw_q;
    for (int c = 0; c < 4; c++) begin
      raw_d[key_of(row_q, 2'(c))] = ~col_s2_q[c];
    end
    sample_now = (div_q == DIV_LAST);
    end_scan   = sample_now && (row_q == 2'd3);
    if (raw_d == prev_q) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    end else begin
      run_d = RUN_W'(1);
    end
    accept = end_scan && (run_d == RUN_MAX) && (raw_d != matrix_q);
  end

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // Row scan timing, per-row sampling and scan-to-scan stability tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      row_q  <= 2'd0;
      raw_q  <= '0;
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      if (sample_now) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
        raw_q <= raw_d;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (end_scan) begin
        prev_q <= raw_d;
        run_q  <= run_d;
      end
    end
  end

  // Accepts debounced snapshots and walks the changed keys in ascending order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      matrix_q   <= '0;
      diff_q     <= '0;
      ptr_q      <= 4'h0;
      ev_q       <= 1'b0;
      ev_idx_q   <= 4'h0;
      ev_press_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ev_q <= 1'b0;
          if (accept) begin
            matrix_q <= raw_d;
            diff_q   <= raw_d ^ matrix_q;
            ptr_q    <= 4'h0;
            state_q  <= ST_WALK;
          end
        end
        ST_WALK: begin
          ev_q       <= diff_q[ptr_q];
          ev_idx_q   <= ptr_q;
          ev_press_q <= matrix_q[ptr_q];
          ptr_q      <= ptr_q + 4'h1;
          if (ptr_q == 4'hF) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign row_n           = ~(4'b0001 << row_q);
  assign keypad_matrix   = matrix_q;
  assign key_event       = ev_q;
  assign key_event_index = ev_idx_q;
  assign key_event_press = ev_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model shorts the driven row to the columns of
// held keys; expected matrices and event lists come from the held key sets.
module tb_keypad_scanner;

  localparam int SD   = 8;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_matrix;
  logic        key_event;
  logic [3:0]  key_event_index;
  logic        key_event_press;

  logic [15:0] held = 16'h0000;
  logic [15:0] model_matrix = 16'h0000;
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Keypad layout: row r, column c -> hex key.
  int km [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

  typedef struct { int idx; int press; int cyc; } ev_t;
  ev_t evq[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .keypad_matrix(keypad_matrix), .key_event(key_event),
    .key_event_index(key_event_index), .key_event_press(key_event_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row_n[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (held[km[r][c]]) col_n[c] = 1'b0;
  end

  // Event recorder.
  always @(negedge clk)
    if (key_event === 1'b1)
      evq.push_back('{int'(key_event_index), int'(key_event_press), cyc});

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Wait for the first negedge of a new scan (row 0, first divider count).
  task automatic align();
    int n;
    bit ok;
    n = 0;
    @(negedge clk);
    while (row_n !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    ok = (n < 100);
    while (row_n !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
    ok = ok && (n < 200);
    n_total++;
    if (!ok) $display("FAIL align: scan start not seen within bound, got row_n=%b", row_n);
    else n_pass++;
  endtask

  // Change the held keys at a scan start and check debounce timing and events.
  task automatic apply_and_check(input logic [15:0] nk, input string tag, input bit do_align);
    logic [15:0] old, diff;
    int expq[$];
    old = model_matrix;
    diff = old ^ nk;
    if (do_align) begin
      align();
      evq.delete();
    end
    held = nk;
    repeat (2 * SCAN + 4) @(negedge clk);
    n_total++;
    if (keypad_matrix !== old)
      $display("FAIL %s_early: matrix=%h need %h", tag, keypad_matrix, old);
    else n_pass++;
    repeat (SCAN) @(negedge clk);
    n_total++;
    if (keypad_matrix !== nk)
      $display("FAIL %s_accept: matrix=%h need %h", tag, keypad_matrix, nk);
    else n_pass++;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 16; k++) if (diff[k]) expq.push_back(k);
    n_total++;
    if (evq.size() != expq.size())
      $display("FAIL %s_evcount: events=%0d need %0d", tag, evq.size(), expq.size());
    else n_pass++;
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      n_total++;
      if (evq[i].idx != expq[i] || evq[i].press != int'(nk[expq[i]]))
        $display("FAIL %s_ev%0d: idx=%0d press=%0d need idx=%0d press=%0d",
                 tag, i, evq[i].idx, evq[i].press, expq[i], nk[expq[i]]);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (evq[i].cyc - evq[i-1].cyc != expq[i] - expq[i-1])
          $display("FAIL %s_gap%0d: gap=%0d need %0d", tag, i,
                   evq[i].cyc - evq[i-1].cyc, expq[i] - expq[i-1]);
        else n_pass++;
      end
    end
    model_matrix = nk;
    evq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (row_n !== 4'b1110 || keypad_matrix !== 16'h0 || key_event !== 1'b0 ||
        key_event_index !== 4'h0 || key_event_press !== 1'b0)
      $display("FAIL reset_state: row_n=%b matrix=%h ev=%b idx=%h press=%b need 1110/0000/0/0/0",
               row_n, keypad_matrix, key_event, key_event_index, key_event_press);
    else n_pass++;
    reset = 1'b0;
    evq.delete();
    repeat (10 * SCAN) @(negedge clk);
    n_total++;
    if (evq.size() != 0 || keypad_matrix !== 16'h0)
      $display("FAIL reset_idle: events=%0d matrix=%h need 0/0000", evq.size(), keypad_matrix);
    else n_pass++;
  endtask

  task automatic test_row_seq();
    logic [3:0] exp;
    align();
    for (int i = 0; i < 33; i++) begin
      exp = ~(4'b0001 << ((i / SD) % 4));
      n_total++;
      if (row_n !== exp) $display("FAIL row_seq%0d: row_n=%b need %b", i, row_n, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_single_key();
    apply_and_check(16'h0040, "key6_press", 1'b1);
    apply_and_check(16'h0000, "key6_release", 1'b1);
  endtask

  task automatic bounce(input logic [15:0] a, input logic [15:0] b, input string tag);
    align();
    evq.delete();
    for (int s = 0; s < 6; s++) begin
      held = (s % 2 == 0) ? a : b;
      repeat (SCAN) @(negedge clk);
    end
    held = model_matrix;
    repeat (4 * SCAN) @(negedge clk);
    n_total++;
    if (keypad_matrix !== model_matrix || evq.size() != 0)
      $display("FAIL %s: matrix=%h events=%0d need %h/0", tag, keypad_matrix, evq.size(), model_matrix);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [15:0] a, b;
    bounce(16'h0020, 16'h0000, "key5_bounce");
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      do b = 16'($urandom_range(0, 16'hFFFF)); while (b == a);
      bounce(a, b, "rand_bounce");
    end
  endtask

  task automatic test_multi();
    apply_and_check(16'h8001, "keys0F", 1'b1);
    apply_and_check(16'h0001, "releaseF", 1'b1);
    apply_and_check(16'h0000, "release0", 1'b1);
  endtask

  task automatic test_reset_walk();
    align();
    evq.delete();
    held = 16'h8001;
    repeat (3 * SCAN + 4) @(negedge clk);
    n_total++;
    if (keypad_matrix !== 16'h8001)
      $display("FAIL walk_pre: matrix=%h need 8001", keypad_matrix);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if (key_event !== 1'b0 || keypad_matrix !== 16'h0 || row_n !== 4'b1110)
      $display("FAIL walk_reset: ev=%b matrix=%h row_n=%b need 0/0000/1110",
               key_event, keypad_matrix, row_n);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_matrix = 16'h0;
    evq.delete();
    apply_and_check(16'h8001, "walk_reaccept", 1'b0);
    apply_and_check(16'h0000, "walk_release", 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] nk;
    for (int i = 0; i < 6; i++) begin
      do nk = 16'($urandom_range(0, 16'hFFFF)); while (nk == model_matrix);
      apply_and_check(nk, "rand", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_row_seq();
    test_single_key();
    test_bounce();
    test_multi();
    test_reset_walk();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
